// File: rtl/hlsm_minmax_range.sv
// Scans the first len entries of an internal register file and reports max, min and max-min.
// Optional MINMAX_INDEX_EN adds max_idx/min_idx: the address of the first occurrence of each.
module hlsm_minmax_range #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic [ADDR_W:0]   len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
`ifdef MINMAX_INDEX_EN
  output logic [ADDR_W-1:0] max_idx,
  output logic [ADDR_W-1:0] min_idx,
`endif
  output logic [DATA_W-1:0] max_diff
);

  typedef enum logic [1:0] {IDLE, INIT, SCAN, FIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] max_q, min_q;
  logic [DATA_W-1:0] max_d, min_d;
  logic [DATA_W-1:0] cur_s;
  logic [ADDR_W:0]   len_clamp_s;
  logic              last_s;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] max_val_q, min_val_q, max_diff_q;
`ifdef MINMAX_INDEX_EN
  logic [ADDR_W-1:0] max_idx_q, min_idx_q, max_idx_d, min_idx_d;
  logic [ADDR_W-1:0] max_idx_out_q, min_idx_out_q;
`endif

  // Storage writes are only accepted while idle so a running scan sees stable data
  always_ff @(posedge Clk) begin
    if (wr_en && (state_q == IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    cur_s = mem_q[idx_q];
    max_d = max_q;
    min_d = min_q;
`ifdef MINMAX_INDEX_EN
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
`endif
    // Strict compares keep the earliest occurrence on ties
    if (cur_s > max_q) begin
      max_d = cur_s;
`ifdef MINMAX_INDEX_EN
      max_idx_d = idx_q;
`endif
    end else begin
      max_d = max_q;
    end
    if (cur_s < min_q) begin
      min_d = cur_s;
`ifdef MINMAX_INDEX_EN
      min_idx_d = idx_q;
`endif
    end else begin
      min_d = min_q;
    end
    if ((len == '0) || (len > DEPTH_L)) begin
      len_clamp_s = DEPTH_L;
    end else begin
      len_clamp_s = len;
    end
    last_s = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      min_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      max_val_q  <= '0;
      min_val_q  <= '0;
      max_diff_q <= '0;
`ifdef MINMAX_INDEX_EN
      max_idx_q     <= '0;
      min_idx_q     <= '0;
      max_idx_out_q <= '0;
      min_idx_out_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (go) begin
            state_q <= INIT;
            len_q   <= len_clamp_s;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          max_q <= mem_q[0];
          min_q <= mem_q[0];
          idx_q <= ADDR_W'(1);
`ifdef MINMAX_INDEX_EN
          max_idx_q <= '0;
          min_idx_q <= '0;
`endif
          if (len_q == (ADDR_W+1)'(1)) begin
            state_q    <= FIN;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            max_val_q  <= mem_q[0];
            min_val_q  <= mem_q[0];
            max_diff_q <= '0;
`ifdef MINMAX_INDEX_EN
            max_idx_out_q <= '0;
            min_idx_out_q <= '0;
`endif
          end else begin
            state_q <= SCAN;
          end
        end
        SCAN: begin
          max_q <= max_d;
          min_q <= min_d;
          idx_q <= idx_q + ADDR_W'(1);
`ifdef MINMAX_INDEX_EN
          max_idx_q <= max_idx_d;
          min_idx_q <= min_idx_d;
`endif
          // Results are registered on entry to FIN so done and data line up
          if (last_s) begin
            state_q    <= FIN;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            max_val_q  <= max_d;
            min_val_q  <= min_d;
            max_diff_q <= max_d - min_d;
`ifdef MINMAX_INDEX_EN
            max_idx_out_q <= max_idx_d;
            min_idx_out_q <= min_idx_d;
`endif
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign max_val  = max_val_q;
  assign min_val  = min_val_q;
  assign max_diff = max_diff_q;
`ifdef MINMAX_INDEX_EN
  assign max_idx  = max_idx_out_q;
  assign min_idx  = min_idx_out_q;
`endif

endmodule

// File: tb/tb_hlsm_minmax_range.sv
// Scoreboard bench for hlsm_minmax_range: directed runs push expected results,
// a negedge monitor pops them whenever done is high.
module tb_hlsm_minmax_range;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       go = 1'b0;
  logic [4:0] len = 5'd0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       busy, done;
  logic [7:0] max_val, min_val, max_diff;
`ifdef MINMAX_INDEX_EN
  logic [3:0] max_idx, min_idx;
`endif

  hlsm_minmax_range dut (
    .Clk(Clk), .Rst(Rst), .go(go), .len(len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .max_val(max_val), .min_val(min_val),
`ifdef MINMAX_INDEX_EN
    .max_idx(max_idx), .min_idx(min_idx),
`endif
    .max_diff(max_diff)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string name;
    int    mx, mn, df, mxi, mni, edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_max"},  int'(max_val),  e.mx);
        check({e.name, "_min"},  int'(min_val),  e.mn);
        check({e.name, "_diff"}, int'(max_diff), e.df);
        check({e.name, "_edge"}, edge_cnt,       e.edge_n);
`ifdef MINMAX_INDEX_EN
        check({e.name, "_max_idx"}, int'(max_idx), e.mxi);
        check({e.name, "_min_idx"}, int'(min_idx), e.mni);
`endif
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = 8'(d);
    step();
    wr_en   = 1'b0;
  endtask

  // go is sampled on the next edge (edge 0); done is expected after edge len
  task automatic start(input string name, input int l, input int l_eff,
                       input int mx, input int mn, input int mxi, input int mni);
    exp_t e;
    e.name = name; e.mx = mx; e.mn = mn; e.df = mx - mn;
    e.mxi = mxi; e.mni = mni; e.edge_n = edge_cnt + 1 + l_eff;
    exp_q.push_back(e);
    go  = 1'b1;
    len = 5'(l);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0) && (t < 100)) begin
      step();
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) step();
  endtask

  task automatic load_t1();
    int v [8] = '{12, 45, 7, 99, 30, 7, 60, 20};
    for (int i = 0; i < 8; i++) wr(i, v[i]);
  endtask

  initial begin
    repeat (2) step();
    Rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_max",  int'(max_val), 0);
    check("rst_min",  int'(min_val), 0);
    check("rst_diff", int'(max_diff), 0);

    // Test 1: basic 8-entry scan
    load_t1();
    start("t1", 8, 8, 99, 7, 3, 2);
    step();
    go = 1'b0;
    check("t1_busy", int'(busy), 1);
    drain("t1");

    // Test 2: len=1, write to mem[0] on the same edge as go
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'd42;
    start("t2", 1, 1, 42, 42, 0, 0);
    step();
    wr_en = 1'b0; go = 1'b0;
    check("t2_busy_on", int'(busy), 1);
    step();
    check("t2_busy_off", int'(busy), 0);
    drain("t2");

    // Test 3: full depth via len=0
    for (int i = 0; i < 16; i++) wr(i, (i == 9) ? 255 : ((i == 14) ? 1 : 128));
    start("t3", 0, 16, 255, 1, 9, 14);
    step();
    go = 1'b0;
    drain("t3");

    // Test 4: reset mid-scan aborts without done, then a fresh run completes
    load_t1();
    go = 1'b1; len = 5'd8;
    step();
    go = 1'b0;
    repeat (2) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("t4_busy", int'(busy), 0);
    check("t4_done", int'(done), 0);
    check("t4_max",  int'(max_val), 0);
    check("t4_min",  int'(min_val), 0);
    check("t4_diff", int'(max_diff), 0);
    repeat (12) step();
    start("t4b", 8, 8, 99, 7, 3, 2);
    step();
    go = 1'b0;
    drain("t4b");

    // Test 5: write and go while busy are both ignored
    start("t5", 8, 8, 99, 7, 3, 2);
    step();
    go = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'd0; go = 1'b1;
    step();
    wr_en = 1'b0; go = 1'b0;
    drain("t5");
    repeat (10) step();
    start("t5_recheck", 8, 8, 99, 7, 3, 2);
    step();
    go = 1'b0;
    drain("t5_recheck");

    // Test 6: all-equal entries
    for (int i = 0; i < 8; i++) wr(i, 255);
    start("t6", 8, 8, 255, 255, 0, 0);
    step();
    go = 1'b0;
    drain("t6");

    // go held high: back-to-back len=1 runs with one idle cycle between them
    start("b2b_a", 1, 1, 255, 255, 0, 0);
    start("b2b_b", 1, 4, 255, 255, 0, 0);
    repeat (5) step();
    go = 1'b0;
    drain("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
